// File: rtl/fwd_register_file_if.sv
// fwd_register_file_if: operand-fetch bus between the issue logic and the register file.
//
// Signals (flattened per pipe / per read slot; read slot index is p*NUM_RD+r):
//   rd_addr  issue -> regfile  read addresses, NUM_PIPES*NUM_RD*ADDR_W
//   wr_en    issue -> regfile  result valid per pipe
//   wr_addr  issue -> regfile  destination register per pipe
//   wr_data  issue -> regfile  result value per pipe
//   rd_data  regfile -> issue  registered operand values
//   rd_fwd   regfile -> issue  operand came from the delay line rather than the array
//
// Modports: master (issue / execution side), slave (register file).
interface fwd_register_file_if #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned NUM_PIPES = 2,
  parameter int unsigned NUM_RD    = 3
);

  logic [NUM_PIPES*NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_PIPES-1:0]               wr_en;
  logic [NUM_PIPES*ADDR_W-1:0]        wr_addr;
  logic [NUM_PIPES*DATA_W-1:0]        wr_data;
  logic [NUM_PIPES*NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_PIPES*NUM_RD-1:0]        rd_fwd;

  modport master (
    output rd_addr,
    output wr_en,
    output wr_addr,
    output wr_data,
    input  rd_data,
    input  rd_fwd
  );

  modport slave (
    input  rd_addr,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output rd_data,
    output rd_fwd
  );

endinterface

// File: rtl/fwd_register_file.sv
// fwd_register_file: multi-issue register file with a per-pipe writeback delay line that mirrors
// execution latency. Results enter stage 0, shift one stage per unstalled edge and commit to the
// architected array when leaving stage FWD_STAGES-1. Reads are registered (1-cycle latency).
//
// Ports:
//   clock  sole clock, rising edge
//   reset  asynchronous, active-low; clears delay lines, array and read outputs
//   stall  freezes delay lines, commit and read outputs; wr_* presented while stalled is dropped
//   bus    fwd_register_file_if.slave (rd_addr, wr_en, wr_addr, wr_data -> rd_data, rd_fwd)
//
// Build option: define FWD_REGFILE_BYPASS_EN for full delay-line forwarding (newest stage first,
// highest pipe wins within a stage). Without it, reads see only the array plus the entry that
// commits on the same edge (write-through); hazards must then be handled at issue.
module fwd_register_file #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned NUM_PIPES  = 2,
  parameter int unsigned NUM_RD     = 3,
  parameter int unsigned FWD_STAGES = 7
) (
  input logic              clock,
  input logic              reset,
  input logic              stall,
  fwd_register_file_if.slave bus
);

  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam int unsigned NUM_SLOTS = NUM_PIPES * NUM_RD;
  localparam int unsigned LAST      = FWD_STAGES - 1;

  logic              dl_valid_q [FWD_STAGES][NUM_PIPES];
  logic [ADDR_W-1:0] dl_addr_q  [FWD_STAGES][NUM_PIPES];
  logic [DATA_W-1:0] dl_data_q  [FWD_STAGES][NUM_PIPES];
  logic [DATA_W-1:0] mem_q      [DEPTH];

  logic [ADDR_W-1:0]           slot_addr [NUM_SLOTS];
  logic [NUM_SLOTS*DATA_W-1:0] rd_data_d, rd_data_q;
  logic [NUM_SLOTS-1:0]        rd_fwd_d, rd_fwd_q;

  // Delay line: stage 0 captures the pipe's result, stage k takes stage k-1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < int'(FWD_STAGES); s++) begin
        for (int p = 0; p < int'(NUM_PIPES); p++) begin
          dl_valid_q[s][p] <= 1'b0;
          dl_addr_q[s][p]  <= '0;
          dl_data_q[s][p]  <= '0;
        end
      end
    end else if (!stall) begin
      for (int p = 0; p < int'(NUM_PIPES); p++) begin
        dl_valid_q[0][p] <= bus.wr_en[p];
        dl_addr_q[0][p]  <= bus.wr_addr[p*ADDR_W +: ADDR_W];
        dl_data_q[0][p]  <= bus.wr_data[p*DATA_W +: DATA_W];
      end
      for (int s = 1; s < int'(FWD_STAGES); s++) begin
        for (int p = 0; p < int'(NUM_PIPES); p++) begin
          dl_valid_q[s][p] <= dl_valid_q[s-1][p];
          dl_addr_q[s][p]  <= dl_addr_q[s-1][p];
          dl_data_q[s][p]  <= dl_data_q[s-1][p];
        end
      end
    end
  end

  // Commit: later loop iterations override earlier ones, so the highest pipe wins a collision.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (!stall) begin
      for (int p = 0; p < int'(NUM_PIPES); p++) begin
        if (dl_valid_q[LAST][p]) begin
          mem_q[dl_addr_q[LAST][p]] <= dl_data_q[LAST][p];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < int'(NUM_SLOTS); k++) begin
      slot_addr[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
    end
  end

  // Read resolution, lowest priority first so each later match overrides:
  // array, then stages oldest to newest, pipes ascending within a stage.
  always_comb begin
    rd_data_d = '0;
    rd_fwd_d  = '0;
    for (int k = 0; k < int'(NUM_SLOTS); k++) begin
      rd_data_d[k*DATA_W +: DATA_W] = mem_q[slot_addr[k]];
`ifdef FWD_REGFILE_BYPASS_EN
      for (int s = int'(FWD_STAGES) - 1; s >= 0; s--) begin
        for (int p = 0; p < int'(NUM_PIPES); p++) begin
          if (dl_valid_q[s][p] && (dl_addr_q[s][p] == slot_addr[k])) begin
            rd_data_d[k*DATA_W +: DATA_W] = dl_data_q[s][p];
            rd_fwd_d[k]                   = 1'b1;
          end
        end
      end
`else
      // Write-through only: the entry committing on this edge.
      for (int p = 0; p < int'(NUM_PIPES); p++) begin
        if (dl_valid_q[LAST][p] && (dl_addr_q[LAST][p] == slot_addr[k])) begin
          rd_data_d[k*DATA_W +: DATA_W] = dl_data_q[LAST][p];
          rd_fwd_d[k]                   = 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
      rd_fwd_q  <= '0;
    end else if (!stall) begin
      rd_data_q <= rd_data_d;
      rd_fwd_q  <= rd_fwd_d;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.rd_fwd  = rd_fwd_q;

endmodule

// File: doc/fwd_register_file.md
# fwd_register_file

Parametrised dual/multi-issue register file with an internal writeback delay line and operand forwarding. It is the SPU operand-fetch stage between the decoder/issue logic and the even/odd execution pipes. Each pipe's results enter a per-pipe delay line that mirrors execution latency, and reads are resolved newest-first against the delay line before falling back to the architected array. The pipe count, data width, register count and forwarding depth are generic.

## Interface
Parameters:
- DATA_W, 128, register width in bits
- ADDR_W, 7, register address width; DEPTH = 2**ADDR_W registers
- NUM_PIPES, 2, issue pipes; pipe 0 = even, pipe 1 = odd
- NUM_RD, 3, read ports per pipe (ra, rb, rc)
- FWD_STAGES, 7, delay-line depth per pipe; must be at least 1

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- stall  in  1  freezes delay lines, commit and read outputs
- rd_addr  in  NUM_PIPES*NUM_RD*ADDR_W  read addresses; slot p*NUM_RD+r
- wr_en  in  NUM_PIPES  result valid per pipe, entering stage 0
- wr_addr  in  NUM_PIPES*ADDR_W  destination register per pipe
- wr_data  in  NUM_PIPES*DATA_W  result value per pipe
- rd_data  out  NUM_PIPES*NUM_RD*DATA_W  registered operand values
- rd_fwd  out  NUM_PIPES*NUM_RD  set when the operand came from the delay line, not the array

## Operation
- Delay line: each pipe has FWD_STAGES entries {valid, addr, data}.
  - When stall is low, every edge shifts the line: stage 0 takes {wr_en, wr_addr, wr_data} and stage k takes stage k-1.
  - The entry leaving stage FWD_STAGES-1 with valid=1 is written to the array at that edge.
- Commit collision: if several pipes commit the same address on one edge, the highest pipe index wins (odd over even).
- Read resolution for each slot, first match wins:
  1. Delay-line entries in stage order 0 to FWD_STAGES-1. Within a stage, the highest pipe index wins.
  2. Array contents.
- Comparisons use the state before the edge. A read never sees a wr_* input presented in the same cycle.
- A read matching the entry that commits on the same edge returns that entry's data with rd_fwd=1.
- Register 0 has no special meaning; it is writable like any other register.
- Stall high:
  - Delay lines hold.
  - No commit.
  - rd_data and rd_fwd hold.
  - wr_* inputs are ignored, so the entry is dropped. Upstream must hold the write until stall clears.
- Reset low, asynchronous, at any time including mid-operation:
  - All delay-line valids cleared.
  - Array cleared to 0.
  - rd_data = 0 and rd_fwd = 0.
  - Any in-flight results are discarded.

## Timing
- Read latency: 1 cycle. Addresses sampled at edge t appear on rd_data after edge t.
- Write visibility:
  - A result presented in the cycle ending at edge t is forwardable to reads sampled at edges t+1 through t+FWD_STAGES.
  - It is in the array and visible via array lookup from edge t+FWD_STAGES onward.
  - Result: there is no read-after-write gap.
- Stall delays all of the above by exactly the number of stalled cycles.
- Reset values of all outputs: rd_data = 0, rd_fwd = 0.
- First edge after reset deasserts: normal operation, empty delay lines.

## Configuration
- Macro FWD_REGFILE_BYPASS_EN.
- Defined: full delay-line forwarding as described above.
- Undefined:
  - Reads consult only the array, plus the committing entry (write-through on the commit edge).
  - Results are invisible until edge t+FWD_STAGES; in-between reads return stale array data.
  - rd_fwd is set only for write-through hits.
  - The hazard check moves to the issue stage.

## Test plan
- **Reset:** assert reset low mid-run with 3 valid in-flight writes; release; read r5 -> rd_data 0, rd_fwd 0, and the in-flight data never appears.
- **Latency sweep:** pipe 0 writes r5 = 128'h3F8A1B9E2C7F1A5B3D6E9C2F5A8B1C4; read r5 on each of the next 8 cycles.
  - Reads 1-7 return the value with rd_fwd=1.
  - Read 8 onward returns the value with rd_fwd=0.
- **Same-cycle collision:** even writes r5 = A7E5F23D6C9B1A4E5F2C7F1A5B3D6E9 and odd writes r5 = 1B3A5C7E9A2B4D6F8C9E2A4B6D8F1A5 on the same edge.
  - Forwarded reads return 1B3A….
  - After commit, the array holds 1B3A….
- **Newest-wins:** pipe 0 writes r7 = 1, then next cycle r7 = 2; read r7 -> 2 (stage 0 beats stage 1), and the array ends at 2.
- **Stall:** write r9 = 0xAA, stall 3 cycles, then unstall.
  - rd_data frozen during the stall.
  - Commit happens at edge t+FWD_STAGES+3.
  - A write presented while stalled is dropped.
- **Macro undefined:** same as the latency sweep.
  - Reads 1-6 return the old value 0.
  - Read 7 (commit edge) returns the new value with rd_fwd=1.
  - Later reads return it with rd_fwd=0.
